// File: rtl/cdc_fifo_reader_if.sv
// Bundles the FIFO read-side pop interface and the downstream valid/ready stream.
// master: the reader block; slave: the FIFO plus the downstream consumer.
interface cdc_fifo_reader_if #(
  parameter int data_width = 32
);
  logic [data_width-1:0] read_data;
  logic                  read_valid;
  logic                  read_ack;
  logic [data_width-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    input  read_data, read_valid, out_ready,
    output read_ack, out_data, out_valid
  );

  modport slave (
    output read_data, read_valid, out_ready,
    input  read_ack, out_data, out_valid
  );
endinterface

// File: rtl/cdc_fifo_reader.sv
// Read-domain consumer for the dual-clock FIFO: credit-based pre-committed pops into a local store.
// Optional CDC_FIFO_READER_COUNT_EN adds a 32-bit count of downstream transfers (word_count).
module cdc_fifo_reader #(
  parameter int data_width   = 32,
  parameter int buffer_depth = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  cdc_fifo_reader_if.master             bus,
  output logic [$clog2(buffer_depth):0] count
`ifdef CDC_FIFO_READER_COUNT_EN
  ,
  output logic [31:0]                   word_count
`endif
);

  localparam int ptr_w = $clog2(buffer_depth);
  localparam int cnt_w = ptr_w + 1;

  logic                  ack_reg;
  logic                  run_reg;
  logic [cnt_w-1:0]      count_reg;
  logic [cnt_w-1:0]      count_next;
  logic [ptr_w-1:0]      wr_ptr_reg;
  logic [ptr_w-1:0]      rd_ptr_reg;
  logic [data_width-1:0] store [buffer_depth];

  logic                  capture;
  logic                  pop;
  logic [cnt_w:0]        credit_sum;

  // A word on read_data is ours only if we acked at the previous edge.
  assign capture = ack_reg && bus.read_valid;
  assign pop     = (count_reg != '0) && bus.out_ready;

  // Reserve a slot for the in-flight pop; downstream pops this cycle are deliberately ignored.
  assign credit_sum   = {1'b0, count_reg} + {{cnt_w{1'b0}}, ack_reg};
  assign bus.read_ack = run_reg && (credit_sum < (cnt_w + 1)'(buffer_depth));

  assign bus.out_valid = (count_reg != '0);
  assign bus.out_data  = store[rd_ptr_reg];
  assign count         = count_reg;

  always_comb begin
    count_next = count_reg;
    case ({capture, pop})
      2'b10:   count_next = count_reg + cnt_w'(1);
      2'b01:   count_next = count_reg - cnt_w'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_reg    <= 1'b0;
      run_reg    <= 1'b0;
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      ack_reg   <= bus.read_ack;
      run_reg   <= 1'b1;
      count_reg <= count_next;
      if (capture) begin
        wr_ptr_reg <= wr_ptr_reg + ptr_w'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + ptr_w'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      store[wr_ptr_reg] <= bus.read_data;
    end
  end

`ifdef CDC_FIFO_READER_COUNT_EN
  logic [31:0] word_count_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_count_reg <= '0;
    end else if (pop) begin
      word_count_reg <= word_count_reg + 32'd1;
    end
  end

  assign word_count = word_count_reg;
`endif

endmodule

// File: tb/tb_cdc_fifo_reader.sv
// Directed bench for cdc_fifo_reader with a behavioural FIFO read side and downstream scoreboard.
module tb_cdc_fifo_reader;

  localparam int dw    = 32;
  localparam int depth = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] count;
`ifdef CDC_FIFO_READER_COUNT_EN
  logic [31:0] word_count;
`endif

  cdc_fifo_reader_if #(.data_width(dw)) bus ();

  cdc_fifo_reader #(.data_width(dw), .buffer_depth(depth)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .count      (count)
`ifdef CDC_FIFO_READER_COUNT_EN
    ,
    .word_count (word_count)
`endif
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          cycle = 0;
  int          pops = 0;
  int          xfers = 0;
  int          max_count = 0;
  bit          manual = 1'b0;
  logic [31:0] fifo_q [$];
  logic [31:0] got_q [$];
  int          got_cyc [$];

  // One clock: FIFO model pops on an acked edge and presents its head one cycle later.
  task automatic tick();
    logic        ack;
    logic        nonempty;
    logic        xfer;
    logic [31:0] head;
    logic [31:0] d;
    ack      = bus.read_ack;
    xfer     = bus.out_valid && bus.out_ready;
    d        = bus.out_data;
    nonempty = (fifo_q.size() != 0);
    head     = nonempty ? fifo_q[0] : 32'hDEAD_BEEF;
    if (ack && nonempty) begin
      void'(fifo_q.pop_front());
      pops++;
    end
    if (xfer) begin
      got_q.push_back(d);
      got_cyc.push_back(cycle);
      xfers++;
    end
    @(posedge clk);
    #1;
    if (!manual) begin
      bus.read_valid = nonempty;
      bus.read_data  = head;
    end
    cycle++;
    if (int'(count) > max_count) max_count = int'(count);
  endtask

  task automatic test_reset();
    reset_n        = 1'b0;
    bus.read_valid = 1'b0;
    bus.read_data  = '0;
    bus.out_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (bus.read_ack !== 1'b0) begin fails++; $display("FAIL reset_ack got=%b exp=0", bus.read_ack); end
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count got=%0d exp=0", count); end
    reset_n = 1'b1;
    tests++; if (bus.read_ack !== 1'b0) begin fails++; $display("FAIL release_ack_first got=%b exp=0", bus.read_ack); end
    tick();
    tests++; if (bus.read_ack !== 1'b1) begin fails++; $display("FAIL release_ack_next got=%b exp=1", bus.read_ack); end
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL release_valid got=%b exp=0", bus.out_valid); end
    $display("[TB] reset: ack=%b valid=%b count=%0d", bus.read_ack, bus.out_valid, count);
  endtask

  task automatic test_stream();
    logic [31:0] exp [3];
    exp[0] = 32'h11; exp[1] = 32'h22; exp[2] = 32'h33;
    got_q.delete(); got_cyc.delete();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) fifo_q.push_back(exp[i]);
    for (int i = 0; i < 8; i++) begin
      tick();
      tests++; if (bus.read_ack !== 1'b1) begin fails++; $display("FAIL stream_ack cyc=%0d got=%b exp=1", i, bus.read_ack); end
      tests++; if (count > 3'd1) begin fails++; $display("FAIL stream_count cyc=%0d got=%0d exp<=1", i, count); end
    end
    tests++;
    if (got_q.size() != 3) begin
      fails++; $display("FAIL stream_size got=%0d exp=3", got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests++; if (got_q[i] !== exp[i]) begin fails++; $display("FAIL stream_data idx=%0d got=%h exp=%h", i, got_q[i], exp[i]); end
        $display("[TB] stream word %0d = %h", i, got_q[i]);
      end
      tests++; if (got_cyc[2] - got_cyc[0] != 2) begin fails++; $display("FAIL stream_consecutive span=%0d exp=2", got_cyc[2] - got_cyc[0]); end
    end
  endtask

  task automatic test_backpressure();
    got_q.delete(); got_cyc.delete();
    bus.out_ready = 1'b0;
    pops = 0;
    for (int i = 0; i < 8; i++) fifo_q.push_back(32'h100 + i);
    repeat (8) tick();
    tests++; if (count !== 3'd4) begin fails++; $display("FAIL bp_count got=%0d exp=4", count); end
    tests++; if (pops != 4) begin fails++; $display("FAIL bp_pops got=%0d exp=4", pops); end
    tests++; if (fifo_q.size() != 4) begin fails++; $display("FAIL bp_fifo_left got=%0d exp=4", fifo_q.size()); end
    tests++; if (bus.read_ack !== 1'b0) begin fails++; $display("FAIL bp_ack got=%b exp=0", bus.read_ack); end
    tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL bp_valid got=%b exp=1", bus.out_valid); end
    tests++; if (bus.out_data !== 32'h100) begin fails++; $display("FAIL bp_hold got=%h exp=00000100", bus.out_data); end
    $display("[TB] backpressure: count=%0d pops=%0d data=%h", count, pops, bus.out_data);
  endtask

  task automatic test_unacked();
    manual = 1'b1;
    bus.read_valid = 1'b1;
    bus.read_data  = 32'hBAD0_0BAD;
    repeat (3) tick();
    tests++; if (count !== 3'd4) begin fails++; $display("FAIL unacked_count got=%0d exp=4", count); end
    tests++; if (bus.read_ack !== 1'b0) begin fails++; $display("FAIL unacked_ack got=%b exp=0", bus.read_ack); end
    tests++; if (bus.out_data !== 32'h100) begin fails++; $display("FAIL unacked_data got=%h exp=00000100", bus.out_data); end
    manual = 1'b0;
    $display("[TB] unacked: count=%0d data=%h", count, bus.out_data);
  endtask

  task automatic test_drain();
    int n;
    bus.out_ready = 1'b1;
    n = 0;
    while (!(got_q.size() == 8 && count == 3'd0) && n < 40) begin
      tick();
      n++;
    end
    tests++;
    if (got_q.size() != 8) begin
      fails++; $display("FAIL drain_size got=%0d exp=8", got_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        tests++; if (got_q[i] !== 32'h100 + i) begin fails++; $display("FAIL drain_data idx=%0d got=%h exp=%h", i, got_q[i], 32'h100 + i); end
      end
    end
    tests++; if (fifo_q.size() != 0) begin fails++; $display("FAIL drain_fifo_left got=%0d exp=0", fifo_q.size()); end
    $display("[TB] drain: words=%0d cycles=%0d", got_q.size(), n);
  endtask

  task automatic test_empty();
    bus.out_ready = 1'b1;
    got_q.delete(); got_cyc.delete();
    repeat (3) begin
      tick();
      tests++; if (bus.read_ack !== 1'b1) begin fails++; $display("FAIL empty_ack got=%b exp=1", bus.read_ack); end
      tests++; if (count !== 3'd0) begin fails++; $display("FAIL empty_count got=%0d exp=0", count); end
      tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL empty_valid got=%b exp=0", bus.out_valid); end
    end
    fifo_q.push_back(32'hA5);
    tick();
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL a5_early got=%b exp=0", bus.out_valid); end
    tick();
    tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL a5_valid got=%b exp=1", bus.out_valid); end
    tests++; if (bus.out_data !== 32'hA5) begin fails++; $display("FAIL a5_data got=%h exp=000000a5", bus.out_data); end
    $display("[TB] empty then push: valid=%b data=%h", bus.out_valid, bus.out_data);
    repeat (3) tick();
  endtask

  task automatic test_random();
    int pushed;
    int n;
    got_q.delete(); got_cyc.delete();
    pushed = 0;
    n = 0;
    while (got_q.size() < 24 && n < 600) begin
      if (pushed < 24 && $urandom_range(0, 1) == 1) begin
        fifo_q.push_back(32'h2000 + pushed);
        pushed++;
      end
      bus.out_ready = ($urandom_range(0, 2) != 0);
      tick();
      n++;
    end
    tests++;
    if (got_q.size() != 24) begin
      fails++; $display("FAIL random_timeout got=%0d exp=24", got_q.size());
    end else begin
      for (int i = 0; i < 24; i++) begin
        tests++; if (got_q[i] !== 32'h2000 + i) begin fails++; $display("FAIL random_order idx=%0d got=%h exp=%h", i, got_q[i], 32'h2000 + i); end
      end
    end
    tests++; if (max_count > depth) begin fails++; $display("FAIL max_count got=%0d exp<=%0d", max_count, depth); end
`ifdef CDC_FIFO_READER_COUNT_EN
    tests++; if (word_count !== 32'(xfers)) begin fails++; $display("FAIL random_word_count got=%0d exp=%0d", word_count, xfers); end
`endif
    $display("[TB] random: words=%0d cycles=%0d max_count=%0d", got_q.size(), n, max_count);
  endtask

`ifdef CDC_FIFO_READER_COUNT_EN
  task automatic test_word_count();
    int start;
    int n;
    bus.out_ready = 1'b0;
    repeat (2) tick();
    force dut.word_count_reg = 32'hFFFF_FFF8;
    #1;
    release dut.word_count_reg;
    #1;
    tests++; if (word_count !== 32'hFFFF_FFF8) begin fails++; $display("FAIL wc_preset got=%h exp=fffffff8", word_count); end
    for (int i = 0; i < 10; i++) fifo_q.push_back(32'h3000 + i);
    bus.out_ready = 1'b1;
    start = xfers;
    n = 0;
    while (xfers - start < 10 && n < 60) begin
      tick();
      n++;
    end
    tests++; if (xfers - start != 10) begin fails++; $display("FAIL wc_timeout got=%0d exp=10", xfers - start); end
    tests++; if (word_count !== 32'h0000_0002) begin fails++; $display("FAIL wc_wrap got=%h exp=00000002", word_count); end
    $display("[TB] word_count after wrap = %h", word_count);
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_unacked();
    test_drain();
    test_empty();
    test_random();
`ifdef CDC_FIFO_READER_COUNT_EN
    test_word_count();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
